// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle M-extension execution unit for the EX stage.
//
// Accepts the R-type ALUControl codes 10000-10111 with both operands and
// returns one registered result plus its destination register tag. Multiplies
// complete after MUL_CYCLES cycles. Divides use a restoring radix-2 loop that
// produces one quotient bit per cycle for XLEN cycles.
//
// Optional build macro: MULDIV_EARLY_OUT_EN
//   defined   - a zero divisor or signed overflow is resolved at accept, and
//               done follows one cycle later.
//   undefined - these cases run the full divide loop. The results are the same.
//
// Ports:
//   clk          clock; all state changes on the rising edge
//   rst          synchronous active-high reset
//   start        issue request
//   alu_control  5-bit ALUControl code; bit 4 marks an M-extension op
//   src_a        rs1 operand (multiplicand / dividend)
//   src_b        rs2 operand (multiplier / divisor)
//   rd_in        destination register tag
//   flush        kills any in-flight op
//   stall        combinational hold for the upstream pipeline
//   done         one-cycle pulse; result and rd_out are valid
//   result       registered result, held until the next done
//   rd_out       tag captured at accept, held with result
module muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [4:0]      alu_control,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  // state  | meaning
  // IDLE   | waiting for start with an M-extension code
  // MUL    | multiply in flight, counter times the latency
  // DIV    | restoring divide, one quotient bit per cycle
  // DONE   | result/rd_out just loaded, done pulse high
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int CNT_MAX = (XLEN > MUL_CYCLES) ? XLEN : MUL_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic [4:0]      tag_q, tag_d;
  // a_q holds the multiplicand, or the dividend shifting out while quotient bits shift in.
  // b_q holds the multiplier, or the divisor magnitude.
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      rd_out_q, rd_out_d;

  logic            idle;
  logic            accept;
  logic            unused_code_bit;

  assign idle            = (state_q == S_IDLE);
  assign accept          = idle & start & alu_control[4] & ~flush;
  assign unused_code_bit = alu_control[3];

  assign stall  = (state_q == S_MUL) | (state_q == S_DIV) | accept;
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign rd_out = rd_out_q;

  // One shared multiplier. In IDLE it sees the live inputs so that
  // MUL_CYCLES == 1 can finish straight from accept.
  logic [1:0]        mul_op;
  logic [XLEN-1:0]   mul_a, mul_b;
  logic [2*XLEN-1:0] mul_a_ext, mul_b_ext, mul_prod;
  logic [XLEN-1:0]   mul_res;

  always_comb begin
    mul_op    = idle ? alu_control[1:0] : op_q;
    mul_a     = idle ? src_a : a_q;
    mul_b     = idle ? src_b : b_q;
    // MULH and MULHSU treat src_a as signed. Only MULH treats src_b as signed.
    mul_a_ext = (mul_op[0]) ? {{XLEN{mul_a[XLEN-1]}}, mul_a} : {{XLEN{1'b0}}, mul_a};
    mul_b_ext = (mul_op == 2'b01) ? {{XLEN{mul_b[XLEN-1]}}, mul_b} : {{XLEN{1'b0}}, mul_b};
    mul_prod  = mul_a_ext * mul_b_ext;
    mul_res   = (mul_op == 2'b00) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
  end

  // A single restoring step. The result is only taken after the last step.
  logic [XLEN:0]   div_shift;
  logic            div_ge;
  logic [XLEN-1:0] quo_nxt, rem_nxt, quo_fix, rem_fix, div_res;

  always_comb begin
    div_shift = {rem_q, a_q[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, b_q});
    rem_nxt   = div_ge ? XLEN'(div_shift - {1'b0, b_q}) : div_shift[XLEN-1:0];
    quo_nxt   = {a_q[XLEN-2:0], div_ge};
    quo_fix   = neg_quo_q ? -quo_nxt : quo_nxt;
    rem_fix   = neg_rem_q ? -rem_nxt : rem_nxt;
    div_res   = op_q[1] ? rem_fix : quo_fix;
  end

  // Decode at accept. A zero divisor already yields an all-ones quotient and
  // a remainder equal to the dividend. Only the quotient sign fix must be suppressed.
  logic            div_signed_in;
  logic            a_neg_in, b_neg_in, div_zero_in;
  logic [XLEN-1:0] a_mag_in, b_mag_in;

  always_comb begin
    div_signed_in = ~alu_control[0];
    a_neg_in      = div_signed_in & src_a[XLEN-1];
    b_neg_in      = div_signed_in & src_b[XLEN-1];
    div_zero_in   = (src_b == '0);
    a_mag_in      = a_neg_in ? -src_a : src_a;
    b_mag_in      = b_neg_in ? -src_b : src_b;
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic            div_ovf_in;
  logic            early_out;
  logic [XLEN-1:0] early_res;

  always_comb begin
    div_ovf_in = div_signed_in & (src_a == {1'b1, {(XLEN-1){1'b0}}}) & (src_b == '1);
    early_out  = div_zero_in | div_ovf_in;
    if (div_zero_in) begin
      early_res = alu_control[1] ? src_a : '1;
    end else begin
      early_res = alu_control[1] ? '0 : src_a;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    tag_d     = tag_q;
    a_d       = a_q;
    b_d       = b_q;
    rem_d     = rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    rd_out_d  = rd_out_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d  = alu_control[1:0];
          tag_d = rd_in;
          if (!alu_control[2]) begin
            a_d = src_a;
            b_d = src_b;
            if (MUL_CYCLES == 1) begin
              state_d  = S_DONE;
              result_d = mul_res;
              rd_out_d = rd_in;
            end else begin
              state_d = S_MUL;
              cnt_d   = CW'(MUL_CYCLES - 1);
            end
          end else begin
            a_d       = a_mag_in;
            b_d       = b_mag_in;
            rem_d     = '0;
            neg_quo_d = (a_neg_in ^ b_neg_in) & ~div_zero_in;
            neg_rem_d = a_neg_in;
            state_d   = S_DIV;
            cnt_d     = CW'(XLEN);
`ifdef MULDIV_EARLY_OUT_EN
            if (early_out) begin
              state_d  = S_DONE;
              cnt_d    = '0;
              result_d = early_res;
              rd_out_d = rd_in;
            end
`endif
          end
        end
      end
      S_MUL: begin
        if (cnt_q == CNT_ONE) begin
          state_d  = S_DONE;
          cnt_d    = '0;
          result_d = mul_res;
          rd_out_d = tag_q;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DIV: begin
        a_d   = quo_nxt;
        rem_d = rem_nxt;
        if (cnt_q == CNT_ONE) begin
          state_d  = S_DONE;
          cnt_d    = '0;
          result_d = div_res;
          rd_out_d = tag_q;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Flush cancels whatever was decided above, including a pending result load.
    if (flush) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      result_d = result_q;
      rd_out_d = rd_out_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      tag_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      rd_out_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      tag_q     <= tag_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rem_q     <= rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      rd_out_q  <= rd_out_d;
    end
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Multi-cycle M-extension execution unit in EX, directly downstream of the R-type ALU control decoder.
- Consumes the 5-bit ALUControl codes 10000–10111 plus both operands.
- Runs an iterative radix-2 divider and a counter-timed multiplier.
- Stalls the pipeline while busy, then returns one registered result with its destination register tag.

Parameters:
XLEN, 32, operand/result width; divider iterates XLEN cycles
MUL_CYCLES, 2, cycles from accept to done for MUL/MULH/MULHU/MULHSU (>=1)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
start  input  1  issue request; accepted only in IDLE with alu_control[4]=1
alu_control  input  5  ALUControl code from the R-type decoder
src_a  input  XLEN  rs1 operand (multiplicand / dividend)
src_b  input  XLEN  rs2 operand (multiplier / divisor)
rd_in  input  5  destination register tag
flush  input  1  kill in-flight op (branch/exception)
stall  output  1  combinational; holds the upstream pipeline
done  output  1  one-cycle pulse; result and rd_out valid
result  output  XLEN  registered result, held until the next done
rd_out  output  5  tag captured at accept, held with result

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; done=0, result=0, rd_out=0, counter=0. Reset mid-operation abandons the op; no done is produced.
- States: IDLE, MUL, DIV, DONE.
- Accept: start=1, state=IDLE, alu_control[4]=1, flush=0 at edge N.
  - Latch operands, rd_in and op.
  - 1000x/1001x codes go to MUL; 101xx codes go to DIV.
  - start with alu_control[4]=0 is ignored: no state change, no done.
- Code map:
  - 10000 MUL: low XLEN bits of the product.
  - 10001 MULH: high bits, signed×signed.
  - 10010 MULHU: high bits, unsigned×unsigned.
  - 10011 MULHSU: high bits, signed src_a × unsigned src_b.
  - 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU.
- MUL: product is formed on 2*XLEN-bit sign/zero-extended operands. Counter counts MUL_CYCLES-1 cycles, then DONE. done is high in cycle N+MUL_CYCLES.
- DIV: restoring divide on magnitudes, one quotient bit per cycle for XLEN cycles. DONE is at cycle N+XLEN+1.
  - Signed ops: quotient is negated when operand signs differ; remainder takes the dividend's sign.
  - Divisor 0: DIV/DIVU give all-ones; REM/REMU give the dividend.
  - Signed overflow (-2^(XLEN-1) / -1): DIV gives -2^(XLEN-1); REM gives 0.
- DONE: done=1 for exactly one cycle; result and rd_out update on entry; next state is IDLE. A new start is accepted no earlier than the cycle after DONE.
- stall = (state==MUL)|(state==DIV)|(state==IDLE & start & alu_control[4] & ~flush). stall is low in the DONE cycle so the pipeline captures result.
- start while not IDLE is ignored; upstream is stalled.
- flush (synchronous) has priority over everything except rst:
  - Forces state to IDLE; done is 0 in that cycle.
  - result and rd_out keep their old values.
  - flush together with start in IDLE: start is ignored.
- done never asserts without a preceding accept; exactly one done per accepted, unflushed op.

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined: at accept, a divisor of 0 or signed overflow is detected, and the unit goes directly to DONE. done is at N+1 with the results specified above.
- Undefined: these cases run the full XLEN iterations, with done at N+XLEN+1 and identical results.
- MUL timing is unaffected either way.

Test Plan:
- MUL 10000, src_a=0xFFFFFFFF, src_b=0x00000002, rd_in=5 -> done at N+2, result=0xFFFFFFFE, rd_out=5; stall high N..N+1, low at N+2.
- MULH/MULHU/MULHSU, src_a=0x80000000, src_b=0xFFFFFFFF -> results 0x00000000, 0x7FFFFFFF, 0x80000000 respectively.
- DIV 10100, src_a=-7 (0xFFFFFFF9), src_b=2 -> done at N+33, result=0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- DIV with src_b=0 -> 0xFFFFFFFF; REMU src_a=0x1234, src_b=0 -> 0x1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0. done at N+33 without MULDIV_EARLY_OUT_EN, N+1 with it.
- Start DIV, assert flush at N+10 -> IDLE at N+11, no done ever, result unchanged. Repeat with rst at N+10 -> done=0, result=0.
- start with alu_control=00000 -> no stall, no done. Start asserted again during DIV busy -> ignored, exactly one done.
